lsu_mc: RTL and testbench

LSU_MC -- requirements
Module: lsu_mc

---
 rtl/lsu_mc.sv | 180 ++++++++++++++++++
 tb/tb_lsu_mc.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mc.sv
// lsu_mc: single-outstanding load/store unit between the decoder and a simple memory bus.
// Aligns and lane-shifts stores, extends loads, and abandons a request that never gets a response.
//
// state | meaning
// IDLE  | ready for a request; illegal requests are rejected with a misalign pulse
// REQ   | memory request presented, held stable until mem_req_ready_i
// WAIT  | request taken by memory, waiting for response or timeout
// WB    | extended load data on the writeback port for one cycle
module lsu_mc #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int ADROFF_WIDTH = 12,
  parameter int RD_WIDTH     = 5,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_ls_i,
  input  logic [1:0]                req_wdth_i,
  input  logic                      req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0]     req_addr_base_i,
  input  logic [ADROFF_WIDTH-1:0]   req_addr_off_i,
  input  logic [DATA_WIDTH-1:0]     req_st_dat_i,
  input  logic [RD_WIDTH-1:0]       req_rd_i,
  output logic                      mem_req_valid_o,
  input  logic                      mem_req_ready_i,
  output logic                      mem_we_o,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   mem_wstrb_o,
  input  logic                      mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
  output logic                      wb_en_o,
  output logic [RD_WIDTH-1:0]       wb_rd_o,
  output logic [DATA_WIDTH-1:0]     wb_dat_o,
  output logic                      misalign_err_o,
  output logic                      bus_err_o,
  output logic                      busy_o
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LO_W   = $clog2(STRB_W);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

  state_t                state;
  logic [7:0]            wait_cnt;
  logic                  ls_q;
  logic                  unsigned_q;
  logic [1:0]            wdth_q;
  logic [LO_W-1:0]       lo_q;
  logic [RD_WIDTH-1:0]   rd_q;

  logic [ADDR_WIDTH-1:0] eff_addr;
  logic [LO_W-1:0]       acc_lo;
  logic                  accept;
  logic                  illegal;
  logic [STRB_W-1:0]     strb_base;
  logic [DATA_WIDTH-1:0] ld_shift;
  logic [DATA_WIDTH-1:0] ld_ext;
  logic                  ld_sign;

  assign eff_addr = req_addr_base_i
                  + {{(ADDR_WIDTH-ADROFF_WIDTH){req_addr_off_i[ADROFF_WIDTH-1]}}, req_addr_off_i};
  assign acc_lo   = eff_addr[LO_W-1:0];
  assign accept   = req_valid_i && req_ready_o;

  // Any set address bit below the access size makes it misaligned.
  always_comb begin
    illegal = (req_wdth_i == 2'd3) && (DATA_WIDTH == 32);
    for (int i = 0; i < LO_W; i++)
      if (i < int'(req_wdth_i) && acc_lo[i]) illegal = 1'b1;
  end

  always_comb begin
    strb_base = '0;
    for (int i = 0; i < STRB_W; i++)
      if (i < (1 << req_wdth_i)) strb_base[i] = 1'b1;
  end

  always_comb begin
    ld_shift = mem_rdata_i >> {lo_q, 3'b000};
    case (wdth_q)
      2'd0:    ld_sign = ld_shift[7];
      2'd1:    ld_sign = ld_shift[15];
      2'd2:    ld_sign = ld_shift[31];
      default: ld_sign = ld_shift[DATA_WIDTH-1];
    endcase
    ld_sign = ld_sign & ~unsigned_q;
    ld_ext  = ld_shift;
    for (int i = 0; i < DATA_WIDTH; i++)
      if (i >= (8 << wdth_q)) ld_ext[i] = ld_sign;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      ls_q            <= 1'b0;
      unsigned_q      <= 1'b0;
      wdth_q          <= '0;
      lo_q            <= '0;
      rd_q            <= '0;
      req_ready_o     <= 1'b1;
      busy_o          <= 1'b0;
      mem_req_valid_o <= 1'b0;
      mem_we_o        <= 1'b0;
      mem_addr_o      <= '0;
      mem_wdata_o     <= '0;
      mem_wstrb_o     <= '0;
      wb_en_o         <= 1'b0;
      wb_rd_o         <= '0;
      wb_dat_o        <= '0;
      misalign_err_o  <= 1'b0;
      bus_err_o       <= 1'b0;
    end else begin
      misalign_err_o <= 1'b0;
      bus_err_o      <= 1'b0;
      wb_en_o        <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (illegal) begin
              misalign_err_o <= 1'b1;
            end else begin
              state           <= REQ;
              req_ready_o     <= 1'b0;
              busy_o          <= 1'b1;
              ls_q            <= req_ls_i;
              unsigned_q      <= req_unsigned_i;
              wdth_q          <= req_wdth_i;
              lo_q            <= acc_lo;
              rd_q            <= req_rd_i;
              mem_req_valid_o <= 1'b1;
              mem_we_o        <= ~req_ls_i;
              mem_addr_o      <= {eff_addr[ADDR_WIDTH-1:LO_W], {LO_W{1'b0}}};
              mem_wdata_o     <= req_ls_i ? '0 : (req_st_dat_i << {acc_lo, 3'b000});
              mem_wstrb_o     <= req_ls_i ? '0 : (strb_base << acc_lo);
            end
          end
        end
        REQ: begin
          if (mem_req_ready_i) begin
            state           <= WAIT;
            mem_req_valid_o <= 1'b0;
            wait_cnt        <= '0;
          end
        end
        WAIT: begin
          if (mem_rsp_valid_i) begin
            if (ls_q) begin
              state    <= WB;
              wb_en_o  <= (rd_q != '0);
              wb_rd_o  <= rd_q;
              wb_dat_o <= ld_ext;
            end else begin
              state       <= IDLE;
              req_ready_o <= 1'b1;
              busy_o      <= 1'b0;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state       <= IDLE;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            bus_err_o   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        WB: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mc.sv
// tb_lsu_mc: directed bench for lsu_mc; expected bus requests and writebacks are queued
// from a byte-lane model when a request is driven and compared when the DUT produces them.
module tb_lsu_mc;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_ready_o, req_ls_i, req_unsigned_i;
  logic [1:0]  req_wdth_i;
  logic [31:0] req_addr_base_i;
  logic [11:0] req_addr_off_i;
  logic [63:0] req_st_dat_i;
  logic [4:0]  req_rd_i;
  logic        mem_req_valid_o, mem_req_ready_i, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_wstrb_o;
  logic        mem_rsp_valid_i;
  logic [63:0] mem_rdata_i;
  logic        wb_en_o;
  logic [4:0]  wb_rd_o;
  logic [63:0] wb_dat_o;
  logic        misalign_err_o, bus_err_o, busy_o;

  lsu_mc #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ADROFF_WIDTH(12), .RD_WIDTH(5), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_ls_i(req_ls_i),
    .req_wdth_i(req_wdth_i), .req_unsigned_i(req_unsigned_i),
    .req_addr_base_i(req_addr_base_i), .req_addr_off_i(req_addr_off_i),
    .req_st_dat_i(req_st_dat_i), .req_rd_i(req_rd_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o), .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rdata_i(mem_rdata_i),
    .wb_en_o(wb_en_o), .wb_rd_o(wb_rd_o), .wb_dat_o(wb_dat_o),
    .misalign_err_o(misalign_err_o), .bus_err_o(bus_err_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ls;
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] wb_dat;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passes = 0;
  int fails  = 0;

  function automatic exp_t model(input logic ls, input logic [1:0] wdth, input logic uns,
                                 input logic [31:0] base, input logic [11:0] off,
                                 input logic [63:0] st, input logic [4:0] rd, input logic [63:0] rdata);
    exp_t e;
    logic [31:0] eff;
    logic [7:0]  strb_tbl [4];
    int lo, nb;
    strb_tbl = '{8'h01, 8'h03, 8'h0F, 8'hFF};
    eff      = base + {{20{off[11]}}, off};
    lo       = int'(eff[2:0]);
    nb       = 1 << wdth;
    e.ls     = ls;
    e.we     = !ls;
    e.rd     = rd;
    e.addr   = {eff[31:3], 3'b000};
    e.wstrb  = ls ? 8'h00 : (strb_tbl[wdth] << lo);
    e.wdata  = st << (8 * lo);
    e.wb_dat = '0;
    for (int b = 0; b < nb; b++) e.wb_dat[8*b +: 8] = rdata[8*(lo+b) +: 8];
    for (int i = 8 * nb; i < 64; i++) e.wb_dat[i] = !uns && e.wb_dat[8*nb-1];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic ls, input logic [1:0] wdth, input logic uns,
                           input logic [31:0] base, input logic [11:0] off,
                           input logic [63:0] st, input logic [4:0] rd);
    req_valid_i     = 1'b1;
    req_ls_i        = ls;
    req_wdth_i      = wdth;
    req_unsigned_i  = uns;
    req_addr_base_i = base;
    req_addr_off_i  = off;
    req_st_dat_i    = st;
    req_rd_i        = rd;
  endtask

  // Zero-wait access: memory accepts at once and responds in the first WAIT cycle.
  task automatic access(input string tag, input logic ls, input logic [1:0] wdth, input logic uns,
                        input logic [31:0] base, input logic [11:0] off, input logic [63:0] st,
                        input logic [4:0] rd, input logic [63:0] rdata);
    exp_t e;
    sb.push_back(model(ls, wdth, uns, base, off, st, rd, rdata));
    drive_req(ls, wdth, uns, base, off, st, rd);
    tick();
    req_valid_i = 1'b0;
    chk({tag, "_mreq_valid"}, 64'(mem_req_valid_o), 64'd1);
    e = sb.pop_front();
    chk({tag, "_we"},    64'(mem_we_o),    64'(e.we));
    chk({tag, "_addr"},  64'(mem_addr_o),  64'(e.addr));
    chk({tag, "_wstrb"}, 64'(mem_wstrb_o), 64'(e.wstrb));
    if (!e.ls) chk({tag, "_wdata"}, mem_wdata_o, e.wdata);
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    chk({tag, "_mreq_drop"}, 64'(mem_req_valid_o), 64'd0);
    chk({tag, "_wb_early"},  64'(wb_en_o),         64'd0);
    mem_rsp_valid_i = 1'b1;
    mem_rdata_i     = rdata;
    tick();
    mem_rsp_valid_i = 1'b0;
    if (e.ls) begin
      chk({tag, "_wb_en"},  64'(wb_en_o),     64'(e.rd != 5'd0));
      chk({tag, "_wb_rd"},  64'(wb_rd_o),     64'(e.rd));
      chk({tag, "_wb_dat"}, wb_dat_o,         e.wb_dat);
      chk({tag, "_ready_wb"}, 64'(req_ready_o), 64'd0);
      tick();
      chk({tag, "_wb_end"},  64'(wb_en_o),     64'd0);
      chk({tag, "_ready"},   64'(req_ready_o), 64'd1);
      chk({tag, "_wb_hold"}, wb_dat_o,         e.wb_dat);
    end else begin
      chk({tag, "_no_wb"}, 64'(wb_en_o),     64'd0);
      chk({tag, "_ready"}, 64'(req_ready_o), 64'd1);
      chk({tag, "_busy"},  64'(busy_o),      64'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    req_valid_i = 1'b0; req_ls_i = 1'b0; req_wdth_i = '0; req_unsigned_i = 1'b0;
    req_addr_base_i = '0; req_addr_off_i = '0; req_st_dat_i = '0; req_rd_i = '0;
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rdata_i = '0;
    #12;
    chk("rst_ready",  64'(req_ready_o),     64'd1);
    chk("rst_busy",   64'(busy_o),          64'd0);
    chk("rst_mreq",   64'(mem_req_valid_o), 64'd0);
    chk("rst_wb_en",  64'(wb_en_o),         64'd0);
    chk("rst_wb_dat", wb_dat_o,             64'd0);
    chk("rst_mis",    64'(misalign_err_o),  64'd0);
    chk("rst_berr",   64'(bus_err_o),       64'd0);
    #1 rst = 1'b0;
    tick();

    access("ldb", 1'b1, 2'd0, 1'b0, 32'h1000, 12'hFFF, 64'd0, 5'd5, 64'h8011_2233_4455_6677);
    chk("ldb_const", wb_dat_o, 64'hFFFF_FFFF_FFFF_FF80);
    access("sth", 1'b0, 2'd1, 1'b0, 32'h2000, 12'h006, 64'hBEEF, 5'd0, 64'd0);
    chk("sth_wb_hold", wb_dat_o, 64'hFFFF_FFFF_FFFF_FF80);
    access("stb", 1'b0, 2'd0, 1'b0, 32'h7003, 12'h000, 64'h5A, 5'd0, 64'd0);
    access("ldw", 1'b1, 2'd2, 1'b0, 32'h1008, 12'hFFC, 64'd0, 5'd9, 64'hF000_0001_0000_0000);

    // Misaligned word load: rejected without a bus request.
    drive_req(1'b1, 2'd2, 1'b0, 32'h3002, 12'h000, 64'd0, 5'd4);
    tick();
    req_valid_i = 1'b0;
    chk("mis_pulse", 64'(misalign_err_o),  64'd1);
    chk("mis_mreq",  64'(mem_req_valid_o), 64'd0);
    chk("mis_ready", 64'(req_ready_o),     64'd1);
    chk("mis_busy",  64'(busy_o),          64'd0);
    tick();
    chk("mis_end",   64'(misalign_err_o),  64'd0);
    chk("mis_mreq2", 64'(mem_req_valid_o), 64'd0);

    // Memory stalls 5 cycles, then never responds.
    sb.push_back(model(1'b1, 2'd3, 1'b0, 32'h4000, 12'h008, 64'd0, 5'd7, 64'd0));
    drive_req(1'b1, 2'd3, 1'b0, 32'h4000, 12'h008, 64'd0, 5'd7);
    tick();
    req_valid_i = 1'b0;
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", 64'(mem_req_valid_o), 64'd1);
      chk("stall_addr",  64'(mem_addr_o),      64'(e.addr));
      chk("stall_we",    64'(mem_we_o),        64'(e.we));
      chk("stall_wstrb", 64'(mem_wstrb_o),     64'(e.wstrb));
      if (k < 4) tick();
    end
    mem_req_ready_i = 1'b1;
    mem_rsp_valid_i = 1'b1;
    mem_rdata_i     = 64'h1234;
    tick();
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    chk("to_mreq_drop", 64'(mem_req_valid_o), 64'd0);
    chk("to_busy",      64'(busy_o),          64'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("to_no_berr", 64'(bus_err_o), 64'd0);
      chk("to_wait",    64'(busy_o),    64'd1);
    end
    tick();
    chk("to_berr",  64'(bus_err_o),   64'd1);
    chk("to_ready", 64'(req_ready_o), 64'd1);
    chk("to_busy0", 64'(busy_o),      64'd0);
    chk("to_no_wb", 64'(wb_en_o),     64'd0);
    mem_rsp_valid_i = 1'b1;
    tick();
    mem_rsp_valid_i = 1'b0;
    chk("stray_berr", 64'(bus_err_o), 64'd0);
    chk("stray_wb",   64'(wb_en_o),   64'd0);
    chk("stray_busy", 64'(busy_o),    64'd0);
    tick();
    chk("stray_wb2",  64'(wb_en_o),   64'd0);
    chk("stray_hold", wb_dat_o,       64'hFFFF_FFFF_F000_0001);

    access("ldhu", 1'b1, 2'd1, 1'b1, 32'h5000, 12'h004, 64'd0, 5'd0, 64'h1111_8123_2222_3333);
    chk("ldhu_const", wb_dat_o, 64'h0000_0000_0000_8123);

    // Reset while waiting for a response.
    sb.push_back(model(1'b1, 2'd2, 1'b0, 32'h6000, 12'h000, 64'd0, 5'd3, 64'd0));
    drive_req(1'b1, 2'd2, 1'b0, 32'h6000, 12'h000, 64'd0, 5'd3);
    tick();
    req_valid_i = 1'b0;
    e = sb.pop_front();
    chk("rw_addr", 64'(mem_addr_o), 64'(e.addr));
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    chk("rw_in_wait", 64'(busy_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rw_addr0",  64'(mem_addr_o),      64'd0);
    chk("rw_mreq0",  64'(mem_req_valid_o), 64'd0);
    chk("rw_busy0",  64'(busy_o),          64'd0);
    chk("rw_ready1", 64'(req_ready_o),     64'd1);
    chk("rw_wbdat0", wb_dat_o,             64'd0);
    chk("rw_berr0",  64'(bus_err_o),       64'd0);
    chk("rw_mis0",   64'(misalign_err_o),  64'd0);
    #2 rst = 1'b0;
    tick();
    mem_rsp_valid_i = 1'b1;
    mem_rdata_i     = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    mem_rsp_valid_i = 1'b0;
    chk("rw_no_wb",   64'(wb_en_o),   64'd0);
    chk("rw_idle",    64'(busy_o),    64'd0);
    chk("rw_dat0",    wb_dat_o,       64'd0);
    tick();
    chk("rw_no_wb2",  64'(wb_en_o),   64'd0);
    chk("rw_no_berr", 64'(bus_err_o), 64'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
